// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the 4-way round-robin capture arbiter.
package mux4_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    // Output register occupancy states
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Next requester index, wrapping 3 -> 0 through 2-bit arithmetic
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// Plain 4:1 data multiplexer shared by the arbiter data path.
module mux_4 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    // Select one of four words by index
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four requesters, round-robin winner captured into a single output register.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [DATA_WIDTH-1:0] din_0,
    input  logic [DATA_WIDTH-1:0] din_1,
    input  logic [DATA_WIDTH-1:0] din_2,
    input  logic [DATA_WIDTH-1:0] din_3,
    output logic [3:0]            gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_src
);

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      rr_ptr_nxt;
    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      out_src_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [DATA_WIDTH-1:0] mux_y;
    logic                  found;
    logic                  capture;

    // A slot opens whenever the output register is empty or being drained
    assign capture   = (state == ST_EMPTY) || out_ready;
    assign out_valid = (state == ST_FULL);

    // Rotating priority: first set req bit at or above rr_ptr, wrapping
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req[rr_ptr + IDX_W'(k)]) begin
                winner = rr_ptr + IDX_W'(k);
                found  = 1'b1;
            end
        end
    end

    // Acceptance strobe, suppressed while reset is held
    always_comb begin
        gnt = '0;
        if (rst_n && capture && found) begin
            gnt[winner] = 1'b1;
        end
    end

    // Winning word steered by the winner index
    mux_4 #(
        .WIDTH(DATA_WIDTH)
    ) u_mux (
        .sel(winner),
        .d0 (din_0),
        .d1 (din_1),
        .d2 (din_2),
        .d3 (din_3),
        .y  (mux_y)
    );

    // Next-state and capture decisions
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        out_data_nxt = out_data;
        out_src_nxt  = out_src;
        case (state)
            ST_EMPTY, ST_FULL: begin
                if (capture) begin
                    if (found) begin
                        state_nxt    = ST_FULL;
                        out_data_nxt = mux_y;
                        out_src_nxt  = winner;
                        rr_ptr_nxt   = idx_inc(winner);
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // State, output word and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            rr_ptr   <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            out_data <= out_data_nxt;
            out_src  <= out_src_nxt;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed corner cases plus random traffic.
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din [4];
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_src;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [33:0] exp_q [$];
    int          m_ptr  = 0;
    bit          m_full = 1'b0;
    logic [3:0]  last_gnt = 4'b0;

    // Monitor state
    bit          mon_held = 1'b0;
    logic [33:0] mon_cur  = '0;

    mux4_rr_arbiter #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din_0    (din[0]),
        .din_1    (din[1]),
        .din_2    (din[2]),
        .din_3    (din[3]),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: predicts grant and queues the captured word
    always @(negedge clk) begin
        int          w;
        bit          cap;
        logic [3:0]  exp_g;
        if (!rst_n) begin
            m_full   = 1'b0;
            m_ptr    = 0;
            last_gnt = 4'b0;
            exp_q.delete();
            chk("reset_gnt", 64'(gnt), 64'(4'b0));
            chk("reset_valid", 64'(out_valid), 64'(1'b0));
        end else begin
            chk("model_valid", 64'(out_valid), 64'(m_full));
            cap = !m_full || out_ready;
            w   = -1;
            if (cap) begin
                for (int k = 0; k < 4; k++) begin
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                end
            end
            exp_g = (w >= 0) ? 4'(1 << w) : 4'b0;
            chk("model_gnt", 64'(gnt), 64'(exp_g));
            last_gnt = exp_g;
            if (w >= 0) begin
                exp_q.push_back({din[w], 2'(w)});
                m_ptr  = (w + 1) % 4;
                m_full = 1'b1;
            end else if (cap) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: pops a new word when presented, holds it while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_held = 1'b0;
        end else if (out_valid) begin
            if (!mon_held) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_underflow: got word %0h src %0d expected none", out_data, out_src);
                    mon_cur = {out_data, out_src};
                end else begin
                    mon_cur = exp_q.pop_front();
                end
                mon_held = 1'b1;
            end
            chk("mon_data", 64'(out_data), 64'(mon_cur[33:2]));
            chk("mon_src", 64'(out_src), 64'(mon_cur[1:0]));
            if (out_ready) mon_held = 1'b0;
        end else begin
            mon_held = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 32'h1000_0000 + 32'(i);

        // Reset held with all requests pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'(4'b0));
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_data", 64'(out_data), 64'(32'h0));
        chk("rst_src", 64'(out_src), 64'(2'd0));
        step();
        rst_n = 1'b1;

        // Round-robin over four persistent requesters
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_gnt", 64'(gnt), 64'(rr_exp[k]));
            if (k > 0) chk("rr_src", 64'(out_src), 64'(k - 1));
            step();
        end

        // Backpressure holds the captured word and blocks grants
        req    = 4'b0100;
        din[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("bp_cap_gnt", 64'(gnt), 64'(4'b0100));
        step();
        req       = 4'b1011;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_gnt", 64'(gnt), 64'(4'b0));
            chk("bp_data", 64'(out_data), 64'(32'hDEAD_BEEF));
            chk("bp_valid", 64'(out_valid), 64'(1'b1));
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_gnt", 64'(gnt), 64'(4'b1000));

        // Skip and wrap: pointer to 3, only requester 1 asking
        step();
        req = 4'b0100;
        @(negedge clk);
        chk("wrap_setup_gnt", 64'(gnt), 64'(4'b0100));
        step();
        req = 4'b0010;
        @(negedge clk);
        chk("wrap_gnt", 64'(gnt), 64'(4'b0010));
        step();
        req    = 4'b1111;
        din[2] = 32'h0BAD_F00D;
        @(negedge clk);
        chk("wrap_ptr2_gnt", 64'(gnt), 64'(4'b0100));

        // Drain a single word
        step();
        req = 4'b0000;
        @(negedge clk);
        chk("drain_gnt", 64'(gnt), 64'(4'b0));
        chk("drain_full", 64'(out_valid), 64'(1'b1));
        step();
        @(negedge clk);
        chk("drain_valid", 64'(out_valid), 64'(1'b0));
        chk("drain_data", 64'(out_data), 64'(32'h0BAD_F00D));
        chk("drain_src", 64'(out_src), 64'(2'd2));

        // Random traffic; requesters hold until granted
        repeat (3000) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || last_gnt[i]) begin
                    req[i] = ($urandom_range(0, 99) < 55);
                    din[i] = $urandom;
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
        end

        // Mid-operation asynchronous reset while full
        step();
        req       = 4'b0001;
        out_ready = 1'b1;
        din[0]    = 32'h5555_AAAA;
        step();
        out_ready = 1'b0;
        #2;
        chk("midrst_pre_valid", 64'(out_valid), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst_gnt", 64'(gnt), 64'(4'b0));
        chk("midrst_data", 64'(out_data), 64'(32'h0));
        step();
        rst_n     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_first_gnt", 64'(gnt), 64'(4'b0001));

        // Final drain; every queued word must have been presented
        step();
        req = 4'b0000;
        repeat (4) step();
        @(negedge clk);
        #1;
        chk("final_valid", 64'(out_valid), 64'(1'b0));
        chk("final_queue", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
